// File: rtl/pipe_pkg.sv
// Shared defaults, bypass-select encoding and field-width helpers for the
// pipeline scoreboard.
package pipe_pkg;

   localparam int NREG_DEF    = 32;
   localparam int AW_DEF      = 5;
   localparam int MAX_LAT_DEF = 4;
   localparam int WB_AGE_DEF  = 3;

   // Bypass select: 0 reads the regfile, k selects the stage holding age k.
   localparam int FWD_RF = 0;

   function automatic int lat_w(input int max_lat);
      return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
   endfunction

   function automatic int age_w(input int wb_age);
      return (wb_age < 1) ? 1 : $clog2(wb_age + 1);
   endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: tracks a single in-flight producer of one register
// as {pending, rem, age}.
module sb_entry
   import pipe_pkg::*;
#(
   parameter  int MAX_LAT = MAX_LAT_DEF,
   parameter  int WB_AGE  = WB_AGE_DEF,
   localparam int LW      = lat_w(MAX_LAT),
   localparam int FW      = age_w(WB_AGE)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          hold,
   input  logic          load,
   input  logic [LW-1:0] load_rem,
   output logic          pending,
   output logic [LW-1:0] rem,
   output logic [FW-1:0] age
);

   // age starts counting once the result exists (rem==0), so a consumer that
   // stalled on this producer picks it up from the youngest bypass stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending <= 1'b0;
         rem     <= '0;
         age     <= '0;
      end else if (!hold) begin
         if (load) begin
            pending <= 1'b1;
            rem     <= load_rem;
            age     <= FW'(1);
         end else if (pending) begin
            if (rem != '0) begin
               rem <= rem - LW'(1);
            end else if (age >= FW'(WB_AGE - 1)) begin
               pending <= 1'b0;
               age     <= '0;
            end else begin
               age <= age + FW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/pipe_scoreboard.sv
// ID-stage hazard scoreboard with bypass selection for a variable-latency
// pipeline. Define PIPE_SB_STATS_EN to build the stall/issue event counters.
module pipe_scoreboard
   import pipe_pkg::*;
#(
   parameter  int NREG    = NREG_DEF,
   parameter  int AW      = AW_DEF,
   parameter  int MAX_LAT = MAX_LAT_DEF,
   parameter  int WB_AGE  = WB_AGE_DEF,
   localparam int LW      = lat_w(MAX_LAT),
   localparam int FW      = age_w(WB_AGE)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          id_valid,
   input  logic          flush,
   input  logic [AW-1:0] id_rs,
   input  logic [AW-1:0] id_rt,
   input  logic          id_rs_used,
   input  logic          id_rt_used,
   input  logic [AW-1:0] id_rd,
   input  logic          id_wr,
   input  logic [LW-1:0] id_lat,
   input  logic          hold,
   output logic          issue,
   output logic          stall,
   output logic [FW-1:0] fwd_rs,
   output logic [FW-1:0] fwd_rt,
   output logic [31:0]   stat_stall,
   output logic [31:0]   stat_issue
);

   logic          pend_v [NREG];
   logic [LW-1:0] rem_v  [NREG];
   logic [FW-1:0] age_v  [NREG];

   logic [LW-1:0] lat_eff;
   logic [LW-1:0] load_rem;
   logic          hz_rs;
   logic          hz_rt;
   logic          stall_c;
   logic          issue_c;
   logic          wr_en;

   assign pend_v[0] = 1'b0;
   assign rem_v[0]  = '0;
   assign age_v[0]  = '0;

   genvar i;
   generate
      for (i = 1; i < NREG; i++) begin : g_entry
         sb_entry #(
            .MAX_LAT (MAX_LAT),
            .WB_AGE  (WB_AGE)
         ) u_entry (
            .clk      (clk),
            .reset    (reset),
            .hold     (hold),
            .load     (wr_en && (id_rd == AW'(i))),
            .load_rem (load_rem),
            .pending  (pend_v[i]),
            .rem      (rem_v[i]),
            .age      (age_v[i])
         );
      end
   endgenerate

   // Out-of-range latencies are folded into 1..MAX_LAT.
   always_comb begin
      lat_eff = id_lat;
      if (id_lat == '0) begin
         lat_eff = LW'(1);
      end else if (id_lat > LW'(MAX_LAT)) begin
         lat_eff = LW'(MAX_LAT);
      end
   end

   assign load_rem = lat_eff - LW'(1);

   assign hz_rs = id_rs_used && (id_rs != '0) && pend_v[id_rs] && (rem_v[id_rs] != '0);
   assign hz_rt = id_rt_used && (id_rt != '0) && pend_v[id_rt] && (rem_v[id_rt] != '0);

   assign stall_c = id_valid && (hold || hz_rs || hz_rt);
   assign issue_c = id_valid && !stall_c && !flush;
   // Register 0 never gets an entry written, so it can never look pending.
   assign wr_en   = issue_c && id_wr && (id_rd != '0);

   // Outputs are forced quiet for the whole time reset is held low.
   assign stall = reset && stall_c;
   assign issue = reset && issue_c;

   assign fwd_rs = (reset && (id_rs != '0) && pend_v[id_rs] && (rem_v[id_rs] == '0))
                   ? age_v[id_rs] : FW'(FWD_RF);
   assign fwd_rt = (reset && (id_rt != '0) && pend_v[id_rt] && (rem_v[id_rt] == '0))
                   ? age_v[id_rt] : FW'(FWD_RF);

`ifdef PIPE_SB_STATS_EN
   // Saturating event counters; hold does not freeze them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_stall <= '0;
         stat_issue <= '0;
      end else begin
         if (stall_c && (stat_stall != '1)) begin
            stat_stall <= stat_stall + 32'd1;
         end
         if (issue_c && (stat_issue != '1)) begin
            stat_issue <= stat_issue + 32'd1;
         end
      end
   end
`else
   assign stat_stall = '0;
   assign stat_issue = '0;
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Self-checking bench for pipe_scoreboard: directed scenarios plus a
// randomized run against a time-based reference model.
module tb_pipe_scoreboard;

   localparam int NREG    = 32;
   localparam int AW      = 5;
   localparam int MAX_LAT = 4;
   localparam int WB_AGE  = 3;
   localparam int LW      = $clog2(MAX_LAT + 1);
   localparam int FW      = $clog2(WB_AGE + 1);
`ifdef PIPE_SB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          id_valid, flush, id_rs_used, id_rt_used, id_wr, hold;
   logic [AW-1:0] id_rs, id_rt, id_rd;
   logic [LW-1:0] id_lat;
   logic          issue, stall;
   logic [FW-1:0] fwd_rs, fwd_rt;
   logic [31:0]   stat_stall, stat_issue;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: per register, the advance-time of its latest issue and
   // its effective latency. Time advances on every edge without hold.
   int unsigned now_t;
   bit          mv [NREG];
   int unsigned mt [NREG];
   int          ml [NREG];
   int unsigned m_stalls, m_issues;

   pipe_scoreboard #(
      .NREG (NREG), .AW (AW), .MAX_LAT (MAX_LAT), .WB_AGE (WB_AGE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .id_valid   (id_valid),
      .flush      (flush),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rs_used (id_rs_used),
      .id_rt_used (id_rt_used),
      .id_rd      (id_rd),
      .id_wr      (id_wr),
      .id_lat     (id_lat),
      .hold       (hold),
      .issue      (issue),
      .stall      (stall),
      .fwd_rs     (fwd_rs),
      .fwd_rt     (fwd_rt),
      .stat_stall (stat_stall),
      .stat_issue (stat_issue)
   );

   always #5 clk = ~clk;

   function automatic int clamp_lat(input int l);
      if (l < 1) return 1;
      if (l > MAX_LAT) return MAX_LAT;
      return l;
   endfunction

   // Producer still visible: result ready at d = L-1, then WB_AGE-1 bypass ages.
   function automatic bit m_pend(input int r);
      int d;
      if (r == 0 || !mv[r]) return 1'b0;
      d = int'(now_t - mt[r]);
      return d <= ml[r] - 1 + WB_AGE - 2;
   endfunction

   function automatic bit m_hz(input int r, input bit used);
      return used && m_pend(r) && (int'(now_t - mt[r]) < ml[r] - 1);
   endfunction

   function automatic int m_fwd(input int r);
      int d;
      if (!m_pend(r)) return 0;
      d = int'(now_t - mt[r]);
      if (d < ml[r] - 1) return 0;
      return 1 + d - (ml[r] - 1);
   endfunction

   task automatic idle();
      id_valid = 0; flush = 0; hold = 0; id_wr = 0;
      id_rs_used = 0; id_rt_used = 0;
      id_rs = '0; id_rt = '0; id_rd = '0; id_lat = '0;
   endtask

   task automatic set_id(input int rs, input bit rsu, input int rt, input bit rtu,
                         input int rd, input bit wr, input int lat);
      id_valid = 1; flush = 0; hold = 0;
      id_rs = AW'(rs); id_rs_used = rsu;
      id_rt = AW'(rt); id_rt_used = rtu;
      id_rd = AW'(rd); id_wr = wr; id_lat = LW'(lat);
   endtask

   task automatic wait_idle(input int n);
      idle();
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 0;
      set_id(3, 1, 4, 1, 3, 1, 2);
      hold = 1;
      #2;
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got=%0b exp=0", stall); end
      n_checks++; if (issue !== 1'b0) begin n_errors++; $display("FAIL reset_issue got=%0b exp=0", issue); end
      @(negedge clk); @(negedge clk);
      n_checks++; if (stat_stall !== 32'd0) begin n_errors++; $display("FAIL reset_stat_stall got=%0d exp=0", stat_stall); end
      n_checks++; if (stat_issue !== 32'd0) begin n_errors++; $display("FAIL reset_stat_issue got=%0d exp=0", stat_issue); end
      idle();
      reset = 1;
      wait_idle(2);
   endtask

   task automatic test_alu_b2b();
      @(negedge clk);
      set_id(0, 0, 0, 0, 8, 1, 1);
      #1;
      n_checks++; if (issue !== 1'b1) begin n_errors++; $display("FAIL alu_issue got=%0b exp=1", issue); end
      @(negedge clk);
      set_id(8, 1, 0, 0, 0, 0, 1);
      #1;
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL alu_stall got=%0b exp=0", stall); end
      n_checks++; if (fwd_rs !== 2'd1) begin n_errors++; $display("FAIL alu_fwd1 got=%0d exp=1", fwd_rs); end
      @(negedge clk); #1;
      n_checks++; if (fwd_rs !== 2'd2) begin n_errors++; $display("FAIL alu_fwd2 got=%0d exp=2", fwd_rs); end
      @(negedge clk); #1;
      n_checks++; if (fwd_rs !== 2'd0) begin n_errors++; $display("FAIL alu_retired got=%0d exp=0", fwd_rs); end
      wait_idle(8);
   endtask

   task automatic test_load_use();
      @(negedge clk);
      set_id(0, 0, 0, 0, 9, 1, 2);
      @(negedge clk);
      set_id(0, 0, 9, 1, 0, 0, 1);
      #1;
      n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL lu_stall got=%0b exp=1", stall); end
      n_checks++; if (issue !== 1'b0) begin n_errors++; $display("FAIL lu_issue0 got=%0b exp=0", issue); end
      @(negedge clk); #1;
      n_checks++; if (issue !== 1'b1) begin n_errors++; $display("FAIL lu_issue1 got=%0b exp=1", issue); end
      n_checks++; if (fwd_rt !== 2'd1) begin n_errors++; $display("FAIL lu_fwd got=%0d exp=1", fwd_rt); end
      wait_idle(8);
   endtask

   task automatic test_waw();
      @(negedge clk);
      set_id(0, 0, 0, 0, 5, 1, 3);
      @(negedge clk);
      set_id(0, 0, 0, 0, 5, 1, 1);
      @(negedge clk);
      set_id(5, 1, 0, 0, 0, 0, 1);
      #1;
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL waw_stall got=%0b exp=0", stall); end
      n_checks++; if (fwd_rs !== 2'd1) begin n_errors++; $display("FAIL waw_fwd got=%0d exp=1", fwd_rs); end
      wait_idle(8);
   endtask

   task automatic test_hold_flush();
      @(negedge clk);
      set_id(0, 0, 0, 0, 4, 1, 3);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         set_id(4, 1, 0, 0, 0, 0, 1);
         hold = 1;
         #1;
         n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL hold_stall c=%0d got=%0b exp=1", c, stall); end
      end
      // Frozen entry still has two cycles of latency left after the hold.
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         hold = 0;
         #1;
         n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL hold_frozen c=%0d got=%0b exp=1", c, stall); end
      end
      @(negedge clk); #1;
      n_checks++; if (fwd_rs !== 2'd1) begin n_errors++; $display("FAIL hold_fwd got=%0d exp=1", fwd_rs); end
      wait_idle(8);
      @(negedge clk);
      set_id(0, 0, 0, 0, 6, 1, 1);
      flush = 1;
      #1;
      n_checks++; if (issue !== 1'b0) begin n_errors++; $display("FAIL flush_issue got=%0b exp=0", issue); end
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL flush_stall got=%0b exp=0", stall); end
      @(negedge clk);
      set_id(6, 1, 0, 0, 0, 0, 1);
      #1;
      n_checks++; if (fwd_rs !== 2'd0) begin n_errors++; $display("FAIL flush_noload got=%0d exp=0", fwd_rs); end
      wait_idle(4);
   endtask

   task automatic test_reg0();
      @(negedge clk);
      set_id(0, 0, 0, 0, 0, 1, 3);
      @(negedge clk);
      set_id(0, 1, 0, 1, 0, 0, 1);
      #1;
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL r0_stall got=%0b exp=0", stall); end
      n_checks++; if (fwd_rs !== 2'd0) begin n_errors++; $display("FAIL r0_fwd got=%0d exp=0", fwd_rs); end
      wait_idle(6);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      set_id(0, 0, 0, 0, 8, 1, 1);
      @(negedge clk);
      set_id(0, 0, 0, 0, 9, 1, 4);
      @(negedge clk);
      set_id(8, 1, 9, 1, 0, 0, 1);
      #1;
      n_checks++; if (fwd_rs !== 2'd2) begin n_errors++; $display("FAIL rm_pre got=%0d exp=2", fwd_rs); end
      #1 reset = 0;
      #1;
      n_checks++; if (fwd_rs !== 2'd0) begin n_errors++; $display("FAIL rm_fwd got=%0d exp=0", fwd_rs); end
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL rm_stall got=%0b exp=0", stall); end
      n_checks++; if (issue !== 1'b0) begin n_errors++; $display("FAIL rm_issue got=%0b exp=0", issue); end
      n_checks++; if (stat_issue !== 32'd0) begin n_errors++; $display("FAIL rm_stat_issue got=%0d exp=0", stat_issue); end
      @(negedge clk);
      reset = 1;
      set_id(0, 0, 9, 1, 0, 0, 1);
      #1;
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL rm_post_stall got=%0b exp=0", stall); end
      n_checks++; if (issue !== 1'b1) begin n_errors++; $display("FAIL rm_post_issue got=%0b exp=1", issue); end
      wait_idle(6);
   endtask

   task automatic test_random();
      bit e_stall, e_issue;
      int e_frs, e_frt;
      int rs, rt, rd, lat;
      bit rsu, rtu, wr;
      @(negedge clk);
      reset = 0;
      idle();
      @(negedge clk);
      reset = 1;
      now_t = 0; m_stalls = 0; m_issues = 0;
      for (int r = 0; r < NREG; r++) begin mv[r] = 0; mt[r] = 0; ml[r] = 1; end
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         rs  = int'($urandom_range(0, 7));  rsu = ($urandom_range(0, 3) != 0);
         rt  = int'($urandom_range(0, 7));  rtu = ($urandom_range(0, 3) != 0);
         rd  = int'($urandom_range(0, 7));  wr  = ($urandom_range(0, 4) != 0);
         lat = int'($urandom_range(0, 7));
         set_id(rs, rsu, rt, rtu, rd, wr, lat);
         id_valid = ($urandom_range(0, 3) != 0);
         hold     = ($urandom_range(0, 7) == 0);
         flush    = ($urandom_range(0, 7) == 0);
         e_stall = id_valid && (hold || m_hz(rs, rsu) || m_hz(rt, rtu));
         e_issue = id_valid && !e_stall && !flush;
         e_frs = m_fwd(rs);
         e_frt = m_fwd(rt);
         #1;
         n_checks++; if (stall !== e_stall) begin n_errors++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, stall, e_stall); end
         n_checks++; if (issue !== e_issue) begin n_errors++; $display("FAIL rnd_issue c=%0d got=%0b exp=%0b", c, issue, e_issue); end
         n_checks++; if (fwd_rs !== FW'(e_frs)) begin n_errors++; $display("FAIL rnd_fwd_rs c=%0d got=%0d exp=%0d", c, fwd_rs, e_frs); end
         n_checks++; if (fwd_rt !== FW'(e_frt)) begin n_errors++; $display("FAIL rnd_fwd_rt c=%0d got=%0d exp=%0d", c, fwd_rt, e_frt); end
         @(posedge clk);
         if (e_stall) m_stalls++;
         if (e_issue) m_issues++;
         if (!hold) now_t++;
         if (e_issue && wr && rd != 0) begin
            mv[rd] = 1; mt[rd] = now_t; ml[rd] = clamp_lat(lat);
         end
      end
      @(negedge clk);
      idle();
      #1;
      n_checks++; if (stat_stall !== (STATS ? m_stalls : 32'd0)) begin n_errors++; $display("FAIL rnd_stat_stall got=%0d exp=%0d", stat_stall, STATS ? m_stalls : 0); end
      n_checks++; if (stat_issue !== (STATS ? m_issues : 32'd0)) begin n_errors++; $display("FAIL rnd_stat_issue got=%0d exp=%0d", stat_issue, STATS ? m_issues : 0); end
      wait_idle(6);
   endtask

   initial begin
      idle();
      reset = 0;
      test_reset();
      test_alu_b2b();
      test_load_use();
      test_waw();
      test_hold_flush();
      test_reg0();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
